// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-front-end constants: PC-select codes, NOP encoding and fetch FSM states.
// Pure declarations; no latency or backpressure of its own.
package fetch_pc_unit_pkg;

   localparam int PCSEL_W = 1;
   localparam logic [PCSEL_W-1:0] PCSEL_PC4  = 1'b0;
   localparam logic [PCSEL_W-1:0] PCSEL_JUMP = 1'b1;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2,
      FETCH_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC mux: hold, sequential +4 (wrapping), or word-aligned redirect target.
// Purely combinational; redirect has priority over advance, no backpressure.
module fetch_next_pc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] jump_target,
   input  logic            redirect,
   input  logic            advance,
   output logic [XLEN-1:0] next_pc
);

   always_comb begin
      next_pc = pc;
      if (redirect) begin
         next_pc = jump_target & ~XLEN'(3);
      end else if (advance) begin
         next_pc = pc + XLEN'(4);
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner with single-outstanding imem handshake; 4 cycles/instr at zero-wait memory.
// All outputs registered; if_valid holds until if_ready & !stall; redirects kill wrong-path fetches.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PCSEL_W-1:0] pc_sel,
   input  logic [XLEN-1:0]    jump_target,
   input  logic               stall,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [XLEN-1:0]    imem_rdata,
   output logic               if_valid,
   output logic [XLEN-1:0]    if_pc,
   output logic [XLEN-1:0]    if_inst,
   input  logic               if_ready,
   output logic               flush
);

   fetch_state_e state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] addr_nxt, if_pc_nxt, if_inst_nxt;
   logic kill, kill_nxt;
   logic req_nxt, valid_nxt, flush_nxt;
   logic redirect, advance;

   assign redirect = (pc_sel == PCSEL_JUMP);
   // A grant for an already-killed request must not step the PC past the redirect target.
   assign advance  = (state == FETCH_REQ) && imem_gnt && !kill;

   fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
      .pc          (pc),
      .jump_target (jump_target),
      .redirect    (redirect),
      .advance     (advance),
      .next_pc     (pc_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= FETCH_IDLE;
         pc        <= RESET_PC;
         kill      <= 1'b0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_inst   <= XLEN'(NOP);
         flush     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         kill      <= kill_nxt;
         imem_req  <= req_nxt;
         imem_addr <= addr_nxt;
         if_valid  <= valid_nxt;
         if_pc     <= if_pc_nxt;
         if_inst   <= if_inst_nxt;
         flush     <= flush_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      kill_nxt    = kill;
      req_nxt     = imem_req;
      addr_nxt    = imem_addr;
      valid_nxt   = if_valid;
      if_pc_nxt   = if_pc;
      if_inst_nxt = if_inst;
      flush_nxt   = redirect;

      case (state)
         FETCH_IDLE: begin
            // Holding off one cycle on redirect lets the request use the new pc.
            if (!stall && !redirect) begin
               addr_nxt  = pc;
               req_nxt   = 1'b1;
               state_nxt = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (redirect) kill_nxt = 1'b1;
            if (imem_gnt) begin
               req_nxt   = 1'b0;
               state_nxt = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid) begin
               kill_nxt  = 1'b0;
               state_nxt = FETCH_IDLE;
               if (!kill && !redirect) begin
                  if_inst_nxt = imem_rdata;
                  if_pc_nxt   = imem_addr;
                  valid_nxt   = 1'b1;
                  state_nxt   = FETCH_HOLD;
               end
            end else if (redirect) begin
               kill_nxt = 1'b1;
            end
         end
         FETCH_HOLD: begin
            if (redirect || (if_ready && !stall)) begin
               valid_nxt = 1'b0;
               state_nxt = FETCH_IDLE;
            end
         end
         default: state_nxt = FETCH_IDLE;
      endcase

      if (redirect) valid_nxt = 1'b0;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios then random traffic, all checked against a
// transaction-level model (architectural pc, live/killed request, held instruction).
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n;
   logic [PCSEL_W-1:0] pc_sel;
   logic [31:0] jump_target;
   logic stall;
   logic imem_req;
   logic [31:0] imem_addr;
   logic imem_gnt;
   logic imem_rvalid;
   logic [31:0] imem_rdata;
   logic if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic if_ready;
   logic flush;

   always #5 clk = ~clk;

   fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_sel      (pc_sel),
      .jump_target (jump_target),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .if_ready    (if_ready),
      .flush       (flush)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // model state
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_req_addr = RST_PC;
   logic [31:0] exp_pc = '0;
   logic [31:0] exp_inst = '0;
   bit live = 0, pending = 0, held = 0, exp_flush = 0, was_reset = 1;
   bit prev_req = 0, prev_gnt = 0, o_req = 0;

   // stimulus knobs
   bit rnd = 0, k_rst = 1, k_jump = 0, k_stall = 0, k_ready = 1, k_force_rv = 0;
   logic [31:0] k_tgt = '0;
   int gnt_wait = 0, rv_wait = 0;

   logic [31:0] rise_log[$];
   int vld_log[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (was_reset) begin
         check_eq("rst_req", {31'b0, imem_req}, 32'd0);
         check_eq("rst_addr", imem_addr, RST_PC);
         check_eq("rst_vld", {31'b0, if_valid}, 32'd0);
         check_eq("rst_if_pc", if_pc, 32'd0);
         check_eq("rst_if_inst", if_inst, NOP);
         check_eq("rst_flush", {31'b0, flush}, 32'd0);
      end else begin
         check_eq("flush", {31'b0, flush}, {31'b0, exp_flush});
         check_eq("if_valid", {31'b0, if_valid}, {31'b0, held});
         if (held) begin
            check_eq("if_pc", if_pc, exp_pc);
            check_eq("if_inst", if_inst, exp_inst);
            check_eq("no_req_in_hold", {31'b0, imem_req}, 32'd0);
         end
         if (imem_req && !prev_req) begin
            check_eq("req_addr", imem_addr, m_pc);
            m_req_addr = imem_addr;
            live = 1;
            rise_log.push_back(imem_addr);
         end
         if (prev_req && !prev_gnt) check_eq("req_held", {31'b0, imem_req}, 32'd1);
         if (imem_req) check_eq("addr_stable", imem_addr, m_req_addr);
      end
      if (if_valid) vld_log.push_back(cyc);
      o_req = imem_req;

      if (rnd) begin
         k_jump  = ($urandom % 8 == 0);
         k_tgt   = $urandom;
         k_stall = ($urandom % 4 == 0);
         k_ready = $urandom % 2;
      end
      rst_n       = !k_rst;
      pc_sel      = k_jump ? PCSEL_JUMP : PCSEL_PC4;
      jump_target = k_tgt;
      stall       = k_stall;
      if_ready    = k_ready;
      if (o_req) begin
         if (rnd) imem_gnt = ($urandom % 3 == 0);
         else if (gnt_wait > 0) begin imem_gnt = 0; gnt_wait--; end
         else imem_gnt = 1;
      end else begin
         imem_gnt = rnd ? 1'($urandom % 2) : 1'b0;
      end
      if (pending) begin
         if (rnd) imem_rvalid = 1'($urandom % 2);
         else if (rv_wait > 0) begin imem_rvalid = 0; rv_wait--; end
         else imem_rvalid = 1;
      end else begin
         imem_rvalid = rnd ? ($urandom % 4 == 0) : k_force_rv;
      end
      imem_rdata = $urandom;

      @(posedge clk);
      prev_req = o_req;
      prev_gnt = imem_gnt;
      if (k_rst) begin
         m_pc = RST_PC; live = 0; pending = 0; held = 0; exp_flush = 0; was_reset = 1;
      end else begin
         was_reset = 0;
         exp_flush = k_jump;
         if (held && k_ready && !k_stall) held = 0;
         if (pending && imem_rvalid) begin
            pending = 0;
            if (live && !k_jump) begin
               held = 1; exp_pc = m_req_addr; exp_inst = imem_rdata;
            end
            live = 0;
         end
         if (o_req && imem_gnt) begin
            pending = 1;
            if (live && !k_jump) m_pc = m_pc + 32'd4;
         end
         if (k_jump) begin
            m_pc = k_tgt & ~32'd3; live = 0; held = 0;
         end
      end
   endtask

   function automatic bit cond(input int w);
      case (w)
         0: return pending;
         1: return o_req;
         default: return held;
      endcase
   endfunction

   task automatic wait_for(input int w, input string tag);
      int n = 0;
      while (!cond(w) && n < 60) begin tick(); n++; end
      check_eq(tag, {31'b0, cond(w)}, 32'd1);
   endtask

   initial begin
      rst_n = 0; pc_sel = PCSEL_PC4; jump_target = '0; stall = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; if_ready = 1;
      repeat (3) tick();

      // sequential zero-wait fetch
      k_rst = 0;
      rise_log.delete(); vld_log.delete();
      repeat (13) tick();
      check_eq("seq_cnt", {31'b0, rise_log.size() >= 3}, 32'd1);
      check_eq("vld_cnt", {31'b0, vld_log.size() >= 3}, 32'd1);
      if (rise_log.size() >= 3) begin
         check_eq("seq0", rise_log[0], 32'h0);
         check_eq("seq1", rise_log[1], 32'h4);
         check_eq("seq2", rise_log[2], 32'h8);
      end
      if (vld_log.size() >= 3) begin
         check_eq("vld_gap0", vld_log[1] - vld_log[0], 32'd4);
         check_eq("vld_gap1", vld_log[2] - vld_log[1], 32'd4);
      end

      // redirect while waiting for a response
      rv_wait = 2;
      wait_for(0, "wait_grant");
      k_jump = 1; k_tgt = 32'h100; tick(); k_jump = 0;
      rise_log.delete();
      repeat (8) tick();
      check_eq("wait_redir", rise_log.size() > 0 ? rise_log[0] : 32'hDEAD_BEEF, 32'h100);

      // redirect while the request is ungranted, unaligned target
      wait_for(2, "wait_hold");
      gnt_wait = 3;
      wait_for(1, "wait_req");
      k_jump = 1; k_tgt = 32'h203; tick(); k_jump = 0;
      rise_log.delete();
      repeat (10) tick();
      check_eq("req_redir", rise_log.size() > 0 ? rise_log[0] : 32'hDEAD_BEEF, 32'h200);

      // stall while holding an instruction
      wait_for(2, "wait_hold2");
      k_stall = 1; repeat (4) tick(); k_stall = 0;
      repeat (3) tick();

      // pc wrap
      k_jump = 1; k_tgt = 32'hFFFF_FFFE; tick(); k_jump = 0;
      rise_log.delete();
      repeat (16) tick();
      check_eq("wrap_cnt", {31'b0, rise_log.size() >= 2}, 32'd1);
      if (rise_log.size() >= 2) begin
         check_eq("wrap_top", rise_log[0], 32'hFFFF_FFFC);
         check_eq("wrap_zero", rise_log[1], 32'h0);
      end

      // reset mid-transaction with a stale response afterwards
      rv_wait = 5;
      wait_for(0, "wait_grant2");
      k_rst = 1; tick();
      k_rst = 0; k_stall = 1; tick();
      k_force_rv = 1; tick();
      k_force_rv = 0; rv_wait = 0; k_stall = 0;
      rise_log.delete();
      repeat (6) tick();
      check_eq("post_rst", rise_log.size() > 0 ? rise_log[0] : 32'hDEAD_BEEF, RST_PC);

      // random traffic
      rnd = 1;
      repeat (3000) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
